// File: rtl/eater_pkg.sv
// Shared definitions for the cpu test harness: checker state encoding,
// fail-reason codes and the data width shared with cpu.
package eater_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FR_NONE     = 2'd0;
  localparam logic [1:0] FR_MISMATCH = 2'd1;
  localparam logic [1:0] FR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/display_trace_checker_trace_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// registered read port; a read of the index being written returns old data.
module trace_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/display_trace_checker.sv
// Records cpu display_data changes into a trace buffer and checks them in
// order against a preloaded expected list, ending in a registered verdict.
module display_trace_checker
  import eater_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = $clog2(TIMEOUT) + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              exp_wr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] display_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_reason,
  output logic [AW:0]       fail_idx,
  output logic [DATA_W-1:0] fail_got,
  output logic [AW:0]       trace_cnt,
  output logic [AW:0]       exp_cnt,
  output logic              exp_ovf,
  output logic [CW-1:0]     cycles,
  output logic [1:0]        dbg_state
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [AW:0]       trace_cnt_q, trace_cnt_d;
  logic [AW:0]       exp_cnt_q, exp_cnt_d;
  logic              exp_ovf_q, exp_ovf_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        fail_reason_q, fail_reason_d;
  logic [AW:0]       fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  logic              exp_we;
  logic              trc_we;
  logic              record;
  logic [DATA_W-1:0] exp_rd;
  logic [DATA_W-1:0] exp_cur;

  // Expected buffer is addressed with the next trace_cnt so that
  // exp[trace_cnt] is already sitting on the read port when a record lands.
  trace_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_exp_mem (
    .clk   (clk),
    .clr   (clr),
    .we    (exp_we),
    .waddr (exp_cnt_q[AW-1:0]),
    .wdata (exp_data),
    .raddr (trace_cnt_d[AW-1:0]),
    .rdata (exp_rd)
  );

  trace_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_trace_mem (
    .clk   (clk),
    .clr   (clr),
    .we    (trc_we),
    .waddr (trace_cnt_q[AW-1:0]),
    .wdata (display_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // A write that coincides with start lands in the entry being prefetched;
  // the bypass register supplies that fresh value instead of the stale read.
  assign exp_cur = byp_q ? byp_data_q : exp_rd;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    prev_d        = prev_q;
    trace_cnt_d   = trace_cnt_q;
    exp_cnt_d     = exp_cnt_q;
    exp_ovf_d     = exp_ovf_q;
    cycles_d      = cycles_q;
    fail_reason_d = fail_reason_q;
    fail_idx_d    = fail_idx_q;
    fail_got_d    = fail_got_q;
    exp_we        = 1'b0;
    trc_we        = 1'b0;
    record        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (exp_wr && !clr) begin
          if (exp_cnt_q == FULL_CNT) begin
            exp_ovf_d = 1'b1;
          end else begin
            exp_we    = 1'b1;
            exp_cnt_d = exp_cnt_q + CNT_ONE;
          end
        end
        if (start) begin
          mode_d      = mode;
          prev_d      = display_data;
          trace_cnt_d = '0;
          cycles_d    = '0;
          state_d     = (exp_cnt_d == '0) ? ST_PASS : ST_RUN;
        end
      end
      ST_RUN: begin
        record = mode_q || (display_data != prev_q);
        if (record) begin
          trc_we      = !clr;
          trace_cnt_d = trace_cnt_q + CNT_ONE;
          prev_d      = display_data;
        end
        if (record && (display_data != exp_cur)) begin
          state_d       = ST_FAIL;
          fail_reason_d = FR_MISMATCH;
          fail_idx_d    = trace_cnt_q;
          fail_got_d    = display_data;
        end else if (record && (trace_cnt_d == exp_cnt_q)) begin
          state_d = ST_PASS;
        end else if (cycles_q == CYC_LAST) begin
          state_d       = ST_FAIL;
          fail_reason_d = FR_TIMEOUT;
          fail_idx_d    = trace_cnt_d;
        end else begin
          cycles_d = cycles_q + CYC_ONE;
        end
      end
      default: begin
      end
    endcase

    busy_d     = (state_d == ST_RUN);
    done_d     = (state_d == ST_PASS) || (state_d == ST_FAIL);
    pass_d     = (state_d == ST_PASS);
    byp_d      = exp_we && (exp_cnt_q[AW-1:0] == trace_cnt_d[AW-1:0]);
    byp_data_d = exp_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      prev_q        <= '0;
      trace_cnt_q   <= '0;
      exp_cnt_q     <= '0;
      exp_ovf_q     <= 1'b0;
      cycles_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_reason_q <= FR_NONE;
      fail_idx_q    <= '0;
      fail_got_q    <= '0;
      byp_q         <= 1'b0;
      byp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      prev_q        <= prev_d;
      trace_cnt_q   <= trace_cnt_d;
      exp_cnt_q     <= exp_cnt_d;
      exp_ovf_q     <= exp_ovf_d;
      cycles_q      <= cycles_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_reason_q <= fail_reason_d;
      fail_idx_q    <= fail_idx_d;
      fail_got_q    <= fail_got_d;
      byp_q         <= byp_d;
      byp_data_q    <= byp_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_reason = fail_reason_q;
  assign fail_idx    = fail_idx_q;
  assign fail_got    = fail_got_q;
  assign trace_cnt   = trace_cnt_q;
  assign exp_cnt     = exp_cnt_q;
  assign exp_ovf     = exp_ovf_q;
  assign cycles      = cycles_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_trace_checker.sv
// Directed scenarios for display_trace_checker with hand-computed verdicts.
module tb_display_trace_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       exp_wr = 1'b0;
  logic [7:0] exp_data = '0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] display_data = '0;
  logic [3:0] rd_idx = '0;
  logic [7:0] rd_data;
  logic       busy, done, pass;
  logic [1:0] fail_reason;
  logic [4:0] fail_idx;
  logic [7:0] fail_got;
  logic [4:0] trace_cnt;
  logic [4:0] exp_cnt;
  logic       exp_ovf;
  logic [5:0] cycles;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  display_trace_checker #(.DATA_W(8), .DEPTH(16), .TIMEOUT(32)) dut (
    .clk(clk), .clr(clr), .exp_wr(exp_wr), .exp_data(exp_data),
    .start(start), .mode(mode), .display_data(display_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done),
    .pass(pass), .fail_reason(fail_reason), .fail_idx(fail_idx),
    .fail_got(fail_got), .trace_cnt(trace_cnt), .exp_cnt(exp_cnt),
    .exp_ovf(exp_ovf), .cycles(cycles), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1; start = 1'b0; exp_wr = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    logic [7:0] v [3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < n; i++) begin
      exp_wr = 1'b1; exp_data = v[i];
      tick();
    end
    exp_wr = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [7:0] base);
    mode = m; display_data = base; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %h exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %h exp 0", pass); end
    checks++; if ({fail_reason, fail_idx, fail_got} !== 15'h0) begin errors++; $display("FAIL reset_fail_fields got %h exp 0", {fail_reason, fail_idx, fail_got}); end
    checks++; if ({trace_cnt, exp_cnt, exp_ovf, cycles} !== 17'h0) begin errors++; $display("FAIL reset_counters got %h exp 0", {trace_cnt, exp_cnt, exp_ovf, cycles}); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %h exp 0", dbg_state); end
  endtask

  task automatic test_pass();
    do_clear();
    load3(8'h00, 8'h05, 8'h0A, 3);
    checks++; if (exp_cnt !== 5'd3) begin errors++; $display("FAIL pass_exp_cnt got %0d exp 3", exp_cnt); end
    do_start(1'b0, 8'hFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy got %h exp 1", busy); end
    tick();
    display_data = 8'h00; tick();
    checks++; if (trace_cnt !== 5'd1) begin errors++; $display("FAIL pass_cnt1 got %0d exp 1", trace_cnt); end
    tick();
    display_data = 8'h05; tick();
    tick();
    checks++; if (pass !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pass_early got pass=%h busy=%h exp 0/1", pass, busy); end
    display_data = 8'h0A; tick();
    checks++; if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pass_verdict got p=%h d=%h b=%h exp 1/1/0", pass, done, busy); end
    checks++; if (trace_cnt !== 5'd3) begin errors++; $display("FAIL pass_trace_cnt got %0d exp 3", trace_cnt); end
    checks++; if (fail_reason !== 2'd0) begin errors++; $display("FAIL pass_reason got %0d exp 0", fail_reason); end
    rd_idx = 4'd1; tick();
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL pass_rd1 got %h exp 05", rd_data); end
    rd_idx = 4'd2; display_data = 8'h77; start = 1'b1; tick();
    start = 1'b0;
    checks++; if (rd_data !== 8'h0A) begin errors++; $display("FAIL pass_rd2 got %h exp 0A", rd_data); end
    checks++; if (pass !== 1'b1 || trace_cnt !== 5'd3) begin errors++; $display("FAIL pass_hold got p=%h cnt=%0d exp 1/3", pass, trace_cnt); end
  endtask

  task automatic test_mismatch();
    do_clear();
    load3(8'h11, 8'h22, 8'h00, 2);
    do_start(1'b0, 8'h00);
    exp_wr = 1'b1; exp_data = 8'h99; tick();
    exp_wr = 1'b0;
    checks++; if (exp_cnt !== 5'd2) begin errors++; $display("FAIL mm_exp_wr_ignored got %0d exp 2", exp_cnt); end
    display_data = 8'h11; tick();
    display_data = 8'h33; tick();
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL mm_verdict got d=%h p=%h exp 1/0", done, pass); end
    checks++; if (fail_reason !== 2'd1) begin errors++; $display("FAIL mm_reason got %0d exp 1", fail_reason); end
    checks++; if (fail_idx !== 5'd1) begin errors++; $display("FAIL mm_idx got %0d exp 1", fail_idx); end
    checks++; if (fail_got !== 8'h33) begin errors++; $display("FAIL mm_got got %h exp 33", fail_got); end
    checks++; if (trace_cnt !== 5'd2) begin errors++; $display("FAIL mm_trace_cnt got %0d exp 2", trace_cnt); end
  endtask

  task automatic test_timeout();
    do_clear();
    load3(8'h01, 8'h00, 8'h00, 1);
    do_start(1'b0, 8'h55);
    for (int i = 0; i < 31; i++) tick();
    checks++; if (busy !== 1'b1 || cycles !== 6'd31) begin errors++; $display("FAIL to_before got busy=%h cyc=%0d exp 1/31", busy, cycles); end
    tick();
    checks++; if (fail_reason !== 2'd2 || done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL to_verdict got r=%0d d=%h p=%h exp 2/1/0", fail_reason, done, pass); end
    checks++; if (cycles !== 6'd31) begin errors++; $display("FAIL to_cycles got %0d exp 31", cycles); end
    checks++; if (trace_cnt !== 5'd0 || fail_idx !== 5'd0) begin errors++; $display("FAIL to_counts got cnt=%0d idx=%0d exp 0/0", trace_cnt, fail_idx); end
  endtask

  task automatic test_modes();
    do_clear();
    load3(8'h07, 8'h07, 8'h08, 3);
    do_start(1'b1, 8'h00);
    display_data = 8'h07; tick();
    display_data = 8'h07; tick();
    checks++; if (busy !== 1'b1 || trace_cnt !== 5'd2) begin errors++; $display("FAIL m1_mid got busy=%h cnt=%0d exp 1/2", busy, trace_cnt); end
    display_data = 8'h08; tick();
    checks++; if (pass !== 1'b1 || trace_cnt !== 5'd3) begin errors++; $display("FAIL m1_pass got p=%h cnt=%0d exp 1/3", pass, trace_cnt); end
    do_clear();
    load3(8'h07, 8'h07, 8'h08, 3);
    do_start(1'b0, 8'h00);
    display_data = 8'h07; tick();
    display_data = 8'h07; tick();
    display_data = 8'h08; tick();
    checks++; if (fail_reason !== 2'd1 || fail_idx !== 5'd1 || fail_got !== 8'h08) begin errors++; $display("FAIL m0_mismatch got r=%0d idx=%0d got=%h exp 1/1/08", fail_reason, fail_idx, fail_got); end
    checks++; if (trace_cnt !== 5'd2) begin errors++; $display("FAIL m0_trace_cnt got %0d exp 2", trace_cnt); end
  endtask

  task automatic test_overflow();
    do_clear();
    exp_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_data = 8'(i); tick();
    end
    checks++; if (exp_cnt !== 5'd16 || exp_ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got cnt=%0d ovf=%h exp 16/0", exp_cnt, exp_ovf); end
    tick();
    exp_wr = 1'b0;
    checks++; if (exp_cnt !== 5'd16 || exp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got cnt=%0d ovf=%h exp 16/1", exp_cnt, exp_ovf); end
    do_clear();
    checks++; if (exp_ovf !== 1'b0 || exp_cnt !== 5'd0) begin errors++; $display("FAIL ovf_clr got ovf=%h cnt=%0d exp 0/0", exp_ovf, exp_cnt); end
    do_start(1'b0, 8'h00);
    checks++; if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_pass got p=%h d=%h b=%h exp 1/1/0", pass, done, busy); end
  endtask

  task automatic test_clr_mid_run();
    do_clear();
    load3(8'h01, 8'h02, 8'h03, 3);
    do_start(1'b0, 8'h00);
    display_data = 8'h01; tick();
    display_data = 8'h02; tick();
    checks++; if (trace_cnt !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL cm_before got cnt=%0d busy=%h exp 2/1", trace_cnt, busy); end
    do_clear();
    checks++; if ({busy, done, pass, fail_reason} !== 5'h0) begin errors++; $display("FAIL cm_flags got %h exp 0", {busy, done, pass, fail_reason}); end
    checks++; if ({trace_cnt, exp_cnt, cycles} !== 16'h0) begin errors++; $display("FAIL cm_counts got %h exp 0", {trace_cnt, exp_cnt, cycles}); end
    do_start(1'b0, 8'h00);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL cm_restart got %h exp 1", pass); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    exp_wr = 1'b1; exp_data = 8'hAA;
    do_start(1'b0, 8'h00);
    exp_wr = 1'b0;
    checks++; if (exp_cnt !== 5'd1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_start got cnt=%0d busy=%h exp 1/1", exp_cnt, busy); end
    display_data = 8'hAA; tick();
    checks++; if (pass !== 1'b1 || fail_reason !== 2'd0) begin errors++; $display("FAIL b2b_pass got p=%h r=%0d exp 1/0", pass, fail_reason); end
    rd_idx = 4'd0; tick();
    checks++; if (rd_data !== 8'hAA) begin errors++; $display("FAIL b2b_rd0 got %h exp AA", rd_data); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_modes();
    test_overflow();
    test_clr_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
